shift_arb_seq: RTL
==================

SHIFT_ARB_SEQ -- requirements
Module: shift_arb_seq

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_a  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-004 Port: req0 / req1  input  1 each  request from requester 0 / 1; held high until the matching grant.
REQ-005 Port: data0 / data1  input  WIDTH each  operand of requester 0 / 1; sampled in the grant cycle.
REQ-006 Port: mode0 / mode1  input  2 each  operation: 00 logical shift left (zero fill), 01 logical shift right (zero fill), 10 rotate left, 11 rotate right.
REQ-007 Port: cnt0 / cnt1  input  4 each  number of single-bit operations, 0..15.
REQ-008 Port: gnt0 / gnt1  output  1 each  registered one-cycle grant pulse; operands captured.
REQ-009 Port: done0 / done1  output  1 each  registered one-cycle completion pulse to the granted requester.
REQ-010 Port: result  output  WIDTH  final operand value; valid with done and held until the next done.
REQ-011 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-013 IDLE, no request: remain in IDLE; gnt0/gnt1 low.
REQ-014 IDLE with req: pick a winner, capture its data/mode/cnt into working registers, pulse its gnt for exactly one cycle, go to SHIFT if cnt != 0, else DONE.
REQ-015 Arbitration: single request wins; if req0 and req1 are both high, the requester not served last wins (round robin); last-served register updates on each grant.
REQ-016 SHIFT: each cycle apply one single-bit operation of the captured mode to the working register and decrement the remaining count; after the operation that takes the count to 0, go to DONE.
REQ-017 DONE: copy the working register to result, pulse done of the granted requester for one cycle, return to IDLE.
REQ-018 Latency: grant in cycle t, done in cycle t+cnt+1; cnt=0 yields done at t+1 with result = data unchanged.
REQ-019 Shift and rotate are modulo WIDTH per step. cnt >= WIDTH rotates wrap (rotate by cnt mod WIDTH). cnt >= WIDTH shifts yield all zeros.
REQ-020 Inputs req/data/mode/cnt are ignored while busy; no grant is issued while busy.
REQ-021 A request still high in IDLE after done is a new transaction and is arbitrated normally. The earliest next grant is the cycle after DONE.
REQ-022 result changes only in the DONE cycle; gnt and done are never high in the same cycle; at most one of gnt0/gnt1 and one of done0/done1 is high.

Reset
REQ-023 While rst_a is low, the following are forced low immediately, independent of clk: gnt0, gnt1, done0, done1, busy, and result (all zeros).
REQ-024 While rst_a is low, state = IDLE, working registers = 0, and last-served = requester 1, so requester 0 wins the first tie.
REQ-025 Reset mid-transaction discards that transaction; no done pulse is issued for it after release.
REQ-026 The first grant is possible on the first rising edge after rst_a deasserts.

Verification
REQ-027 Bench: req0, data0=0x81, mode0=10, cnt0=1 -> gnt0 at t, done0 at t+2, result=0x03.
REQ-028 Bench: req1, data1=0xFF, mode1=00, cnt1=3 -> done1 at t+4, result=0xF8, busy high t+1..t+4.
REQ-029 Bench: req0 and req1 high together after reset -> gnt0 first. Both kept/re-raised -> next grant gnt1, then gnt0 (alternating).
REQ-030 Bench: req0, data0=0x5A, mode0=11, cnt0=0 -> done0 at t+1, result=0x5A.
REQ-031 Bench: req0, data0=0x01, mode0=11, cnt0=9 -> result=0x80. Same stimulus with mode0=01 -> result=0x00.
REQ-032 Bench: assert rst_a low during SHIFT -> busy, gnt, done and result go 0 without a clock edge. After release, no done pulse occurs until a new request.

Source files
------------

// File: rtl/shift_arb_seq.sv
// Two-requester round-robin arbiter feeding a sequential shift/rotate unit.
// Grant is issued from IDLE; the FSM then shifts one bit per cycle and reports done.
module shift_arb_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [1:0]       mode0,
  input  logic [1:0]       mode1,
  input  logic [3:0]       cnt0,
  input  logic [3:0]       cnt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] nxt;
  logic [1:0]       mode;
  logic [3:0]       rem;
  logic             owner;
  logic             last;
  logic             win1;

  // On a tie, whoever was not served last wins.
  assign win1 = req1 & (~req0 | ~last);
  assign busy = (state != IDLE);

  always_comb begin
    nxt = work;
    unique case (mode)
      2'b00: nxt = {work[WIDTH-2:0], 1'b0};
      2'b01: nxt = {1'b0, work[WIDTH-1:1]};
      2'b10: nxt = {work[WIDTH-2:0], work[WIDTH-1]};
      2'b11: nxt = {work[0], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state  <= IDLE;
      work   <= '0;
      mode   <= 2'b00;
      rem    <= 4'd0;
      owner  <= 1'b0;
      last   <= 1'b1;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          // The grant cycle itself is spent in IDLE; work starts after it.
          if (gnt0 || gnt1) begin
            if (rem == 4'd0) begin
              state  <= DONE;
              result <= work;
              done0  <= ~owner;
              done1  <= owner;
            end else begin
              state <= SHIFT;
            end
          end else if (req0 || req1) begin
            owner <= win1;
            last  <= win1;
            gnt0  <= ~win1;
            gnt1  <= win1;
            work  <= win1 ? data1 : data0;
            mode  <= win1 ? mode1 : mode0;
            rem   <= win1 ? cnt1 : cnt0;
          end
        end
        SHIFT: begin
          work <= nxt;
          rem  <= rem - 4'd1;
          if (rem == 4'd1) begin
            state  <= DONE;
            result <= nxt;
            done0  <= ~owner;
            done1  <= owner;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
